// File: rtl/ppg_dual_ma_filter.sv
// rtl/ppg_dual_ma_filter.sv - dual-channel (IR/RED) moving-sum filter for PPG samples
//
// Purpose: keeps a TAPS-sample sliding window per channel and publishes the
// window sum of both channels together, once per sample tick, after the window
// has been filled with TAPS fresh samples.
//
// Ports:
//   CLK               system clock
//   rst_n             asynchronous active-low reset
//   CLK_Filter        sample-rate toggle, rising edge (seen in CLK domain) = sample tick
//   enable            high while the upstream controller is operating; low forces IDLE
//   IR_ADC_Value      8-bit IR sample
//   RED_ADC_Value     8-bit RED sample
//   Out_IR_Filtered   IR window sum, zero-extended to OUT_W
//   Out_RED_Filtered  RED window sum, zero-extended to OUT_W
//   filt_valid        one-cycle strobe when outputs update with a full window
//   filling           high while the window is being filled after enable
module ppg_dual_ma_filter #(
  parameter int LOG2_TAPS = 5,
  parameter int OUT_W     = 20
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             CLK_Filter,
  input  logic             enable,
  input  logic [7:0]       IR_ADC_Value,
  input  logic [7:0]       RED_ADC_Value,
  output logic [OUT_W-1:0] Out_IR_Filtered,
  output logic [OUT_W-1:0] Out_RED_Filtered,
  output logic             filt_valid,
  output logic             filling
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int SW   = 8 + LOG2_TAPS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state;
  logic                 cf_d;
  logic                 tick;
  logic [LOG2_TAPS-1:0] wr_ptr;
  logic [LOG2_TAPS-1:0] fill_cnt;
  logic [SW-1:0]        sum_ir;
  logic [SW-1:0]        sum_red;
  logic [SW-1:0]        sum_ir_nxt;
  logic [SW-1:0]        sum_red_nxt;
  logic [7:0]           old_ir;
  logic [7:0]           old_red;
  logic [7:0]           ring_ir  [TAPS];
  logic [7:0]           ring_red [TAPS];

  // CLK_Filter is only ever sampled as data; a rising edge marks a new sample.
  assign tick = enable & CLK_Filter & ~cf_d;

  // While filling, the slot under wr_ptr holds stale data that is not part of
  // the window, so nothing is subtracted. In RUN the slot holds the oldest
  // sample, which leaves the window as the new one enters. The sum always
  // contains the sample being removed, so the modular arithmetic never wraps
  // in the final result.
  always_comb begin
    old_ir      = '0;
    old_red     = '0;
    if (state == RUN) begin
      old_ir  = ring_ir[wr_ptr];
      old_red = ring_red[wr_ptr];
    end
    sum_ir_nxt  = sum_ir  + SW'(IR_ADC_Value)  - SW'(old_ir);
    sum_red_nxt = sum_red + SW'(RED_ADC_Value) - SW'(old_red);
  end

  // Sample storage carries no reset; it is only read once written in this pass.
  always_ff @(posedge CLK) begin
    if (tick && (state == FILL || state == RUN)) begin
      ring_ir[wr_ptr]  <= IR_ADC_Value;
      ring_red[wr_ptr] <= RED_ADC_Value;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cf_d             <= 1'b0;
      wr_ptr           <= '0;
      fill_cnt         <= '0;
      sum_ir           <= '0;
      sum_red          <= '0;
      Out_IR_Filtered  <= '0;
      Out_RED_Filtered <= '0;
      filt_valid       <= 1'b0;
      filling          <= 1'b0;
    end else begin
      cf_d       <= CLK_Filter;
      filt_valid <= 1'b0;
      if (!enable) begin
        // Dropping enable discards the window; a tick on this cycle is ignored.
        state            <= IDLE;
        wr_ptr           <= '0;
        fill_cnt         <= '0;
        sum_ir           <= '0;
        sum_red          <= '0;
        Out_IR_Filtered  <= '0;
        Out_RED_Filtered <= '0;
        filling          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= FILL;
            filling  <= 1'b1;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            sum_ir   <= '0;
            sum_red  <= '0;
          end
          FILL: begin
            if (tick) begin
              sum_ir   <= sum_ir_nxt;
              sum_red  <= sum_red_nxt;
              wr_ptr   <= wr_ptr + LOG2_TAPS'(1);
              fill_cnt <= fill_cnt + LOG2_TAPS'(1);
              if (fill_cnt == LOG2_TAPS'(TAPS - 1)) begin
                state            <= RUN;
                filling          <= 1'b0;
                Out_IR_Filtered  <= OUT_W'(sum_ir_nxt);
                Out_RED_Filtered <= OUT_W'(sum_red_nxt);
                filt_valid       <= 1'b1;
              end
            end
          end
          RUN: begin
            if (tick) begin
              sum_ir           <= sum_ir_nxt;
              sum_red          <= sum_red_nxt;
              wr_ptr           <= wr_ptr + LOG2_TAPS'(1);
              Out_IR_Filtered  <= OUT_W'(sum_ir_nxt);
              Out_RED_Filtered <= OUT_W'(sum_red_nxt);
              filt_valid       <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            filling <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
